// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle control unit and the datapath muxes it steers.
// Holds the FSM state enum, MIPS opcode/funct values and every control-field encoding.
package mc_ctrl_pkg;

   typedef enum logic [4:0] {
      ST_RESET     = 5'd0,
      ST_FETCH     = 5'd1,
      ST_DECODE    = 5'd2,
      ST_EXEC_R    = 5'd3,
      ST_WB_R      = 5'd4,
      ST_ADDI      = 5'd5,
      ST_WB_I      = 5'd6,
      ST_MEM_ADDR  = 5'd7,
      ST_MEM_READ  = 5'd8,
      ST_MEM_WB    = 5'd9,
      ST_MEM_WRITE = 5'd10,
      ST_BRANCH    = 5'd11,
      ST_JUMP      = 5'd12,
      ST_JR        = 5'd13,
      ST_MULT      = 5'd14,
      ST_DIV       = 5'd15,
      ST_MFHILO    = 5'd16,
      ST_EXC_SAVE  = 5'd17,
      ST_EXC_LOAD  = 5'd18,
      ST_EXC_JUMP  = 5'd19
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_MFHI  = 6'h10;
   localparam logic [5:0] FN_MFLO  = 6'h12;
   localparam logic [5:0] FN_MULT  = 6'h18;
   localparam logic [5:0] FN_DIV   = 6'h1A;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_AND   = 6'h24;

   localparam logic [2:0] ALU_PASS = 3'b000;
   localparam logic [2:0] ALU_ADD  = 3'b001;
   localparam logic [2:0] ALU_SUB  = 3'b010;
   localparam logic [2:0] ALU_AND  = 3'b011;

   localparam logic [1:0] SRCA_PC  = 2'b00;
   localparam logic [1:0] SRCA_RAA = 2'b01;
   localparam logic [1:0] SRCA_A   = 2'b10;

   localparam logic [2:0] SRCB_B        = 3'b000;
   localparam logic [2:0] SRCB_FOUR     = 3'b001;
   localparam logic [2:0] SRCB_SEXT     = 3'b010;
   localparam logic [2:0] SRCB_MDR      = 3'b011;
   localparam logic [2:0] SRCB_SEXT_SH2 = 3'b100;

   localparam logic [2:0] PCS_ALU    = 3'b000;
   localparam logic [2:0] PCS_ALUOUT = 3'b001;
   localparam logic [2:0] PCS_JUMP   = 3'b010;
   localparam logic [2:0] PCS_A      = 3'b011;
   localparam logic [2:0] PCS_EPC    = 3'b100;
   localparam logic [2:0] PCS_EXC    = 3'b101;

   localparam logic [2:0] M2R_ALUOUT = 3'b000;
   localparam logic [2:0] M2R_MDR    = 3'b001;
   localparam logic [2:0] M2R_HILO   = 3'b010;

   localparam logic [1:0] DST_RT = 2'b00;
   localparam logic [1:0] DST_RD = 2'b01;

   localparam logic [1:0] IORD_PC     = 2'b00;
   localparam logic [1:0] IORD_ALUOUT = 2'b01;
   localparam logic [1:0] IORD_EXC    = 2'b10;

   localparam logic [1:0] CB_EQ = 2'b00;
   localparam logic [1:0] CB_NE = 2'b01;

   localparam logic [1:0] EC_INVALID = 2'b00;
   localparam logic [1:0] EC_OVF     = 2'b01;
   localparam logic [1:0] EC_DIVZ    = 2'b10;

   function automatic logic [2:0] funct_alu(input logic [5:0] funct);
      case (funct)
         FN_ADD:  return ALU_ADD;
         FN_SUB:  return ALU_SUB;
         FN_AND:  return ALU_AND;
         default: return ALU_PASS;
      endcase
   endfunction

endpackage

// File: rtl/mc_control_unit_if.sv
// Control-unit <-> datapath bundle: instruction fields and status flags in, control word out.
// master = control unit, slave = datapath.
interface mc_control_unit_if;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       overflow;
   logic       div_zero;

   logic       PC_W;
   logic       PCWriteCond;
   logic       Mem_W;
   logic       MDR_W;
   logic       IR_W;
   logic       RB_W;
   logic       Reg_AB_W;
   logic       ALU_Out_Reg_W;
   logic       EPC_W;
   logic       HILO_W;
   logic       divOrMult;
   logic       controlDivMult;
   logic [1:0] ALUSrcA;
   logic [2:0] ALUSrcB;
   logic [2:0] ALUControl;
   logic [2:0] PCSource;
   logic [2:0] memToReg;
   logic [1:0] regDST;
   logic [1:0] IorD;
   logic [1:0] CB;
   logic [1:0] EC_CTRL;
   logic [4:0] state_dbg;

   modport master (
      input  opcode, funct, overflow, div_zero,
      output PC_W, PCWriteCond, Mem_W, MDR_W, IR_W, RB_W, Reg_AB_W, ALU_Out_Reg_W,
             EPC_W, HILO_W, divOrMult, controlDivMult, ALUSrcA, ALUSrcB, ALUControl,
             PCSource, memToReg, regDST, IorD, CB, EC_CTRL, state_dbg
   );

   modport slave (
      output opcode, funct, overflow, div_zero,
      input  PC_W, PCWriteCond, Mem_W, MDR_W, IR_W, RB_W, Reg_AB_W, ALU_Out_Reg_W,
             EPC_W, HILO_W, divOrMult, controlDivMult, ALUSrcA, ALUSrcB, ALUControl,
             PCSource, memToReg, regDST, IorD, CB, EC_CTRL, state_dbg
   );
endinterface

// File: rtl/mc_control_unit.sv
// Multicycle MIPS-subset control FSM: Moore control word from a registered state,
// one shared saturating wait counter, and a latched exception cause.
//
// state     | meaning
// ----------+-----------------------------------------------
// RESET     | held in reset, all controls low
// FETCH     | read IR from PC for MEM_WAIT cycles, PC <= PC+4
// DECODE    | load A/B, precompute branch target, dispatch
// EXEC_R    | add/sub/and into ALUOut, overflow check
// WB_R      | ALUOut -> rd
// ADDI      | A + imm into ALUOut, overflow check
// WB_I      | ALUOut -> rt
// MEM_ADDR  | A + imm effective address
// MEM_READ  | data read for MEM_WAIT cycles, MDR load
// MEM_WB    | MDR -> rt
// MEM_WRITE | single-cycle store
// BRANCH    | beq/bne compare, conditional PC write
// JUMP      | PC <= jump target
// JR        | PC <= A
// MULT      | multiplier runs, HI/LO captured on last cycle
// DIV       | divider runs, div-by-zero trap on first cycle
// MFHILO    | HI or LO -> rd
// EXC_SAVE  | EPC <= PC, cause held in EC_CTRL
// EXC_LOAD  | read exception vector for MEM_WAIT cycles
// EXC_JUMP  | PC <= exception handler
module mc_control_unit
   import mc_ctrl_pkg::*;
#(
   parameter int MEM_WAIT    = 2,
   parameter int MULT_CYCLES = 33,
   parameter int DIV_CYCLES  = 33
) (
   input  logic               clk,
   input  logic               reset,
   mc_control_unit_if.master  bus
);

   localparam logic [5:0] MEM_LAST  = 6'(MEM_WAIT - 1);
   localparam logic [5:0] MULT_LAST = 6'(MULT_CYCLES - 1);
   localparam logic [5:0] DIV_LAST  = 6'(DIV_CYCLES - 1);

   state_t     state_q, state_d;
   logic [5:0] cnt_q;
   logic [1:0] ec_q, ec_d;
   logic       arith_ovf;

   assign arith_ovf = ((bus.funct == FN_ADD) || (bus.funct == FN_SUB)) && bus.overflow;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_RESET;
         cnt_q   <= '0;
         ec_q    <= EC_INVALID;
      end else begin
         state_q <= state_d;
         ec_q    <= ec_d;
         if (state_d != state_q)
            cnt_q <= '0;
         else if (cnt_q != 6'h3F)
            cnt_q <= cnt_q + 6'd1;
      end
   end

   always_comb begin
      state_d = state_q;
      ec_d    = ec_q;
      case (state_q)
         ST_RESET: state_d = ST_FETCH;
         ST_FETCH: if (cnt_q == MEM_LAST) state_d = ST_DECODE;
         ST_DECODE: begin
            case (bus.opcode)
               OP_RTYPE: begin
                  case (bus.funct)
                     FN_ADD, FN_SUB, FN_AND: state_d = ST_EXEC_R;
                     FN_MULT:                state_d = ST_MULT;
                     FN_DIV:                 state_d = ST_DIV;
                     FN_MFHI, FN_MFLO:       state_d = ST_MFHILO;
                     FN_JR:                  state_d = ST_JR;
                     default: begin
                        state_d = ST_EXC_SAVE;
                        ec_d    = EC_INVALID;
                     end
                  endcase
               end
               OP_ADDI:        state_d = ST_ADDI;
               OP_LW, OP_SW:   state_d = ST_MEM_ADDR;
               OP_BEQ, OP_BNE: state_d = ST_BRANCH;
               OP_J:           state_d = ST_JUMP;
               default: begin
                  state_d = ST_EXC_SAVE;
                  ec_d    = EC_INVALID;
               end
            endcase
         end
         ST_EXEC_R: begin
            if (arith_ovf) begin
               state_d = ST_EXC_SAVE;
               ec_d    = EC_OVF;
            end else begin
               state_d = ST_WB_R;
            end
         end
         ST_ADDI: begin
            if (bus.overflow) begin
               state_d = ST_EXC_SAVE;
               ec_d    = EC_OVF;
            end else begin
               state_d = ST_WB_I;
            end
         end
         ST_MEM_ADDR: state_d = (bus.opcode == OP_SW) ? ST_MEM_WRITE : ST_MEM_READ;
         ST_MEM_READ: if (cnt_q == MEM_LAST) state_d = ST_MEM_WB;
         ST_MULT:     if (cnt_q == MULT_LAST) state_d = ST_FETCH;
         ST_DIV: begin
            if ((cnt_q == 6'd0) && bus.div_zero) begin
               state_d = ST_EXC_SAVE;
               ec_d    = EC_DIVZ;
            end else if (cnt_q == DIV_LAST) begin
               state_d = ST_FETCH;
            end
         end
         ST_EXC_SAVE: state_d = ST_EXC_LOAD;
         ST_EXC_LOAD: if (cnt_q == MEM_LAST) state_d = ST_EXC_JUMP;
         ST_WB_R, ST_WB_I, ST_MEM_WB, ST_MEM_WRITE, ST_BRANCH,
         ST_JUMP, ST_JR, ST_MFHILO, ST_EXC_JUMP: state_d = ST_FETCH;
         default: state_d = ST_RESET;
      endcase
   end

   assign bus.state_dbg = state_q;

   always_comb begin
      bus.PC_W           = 1'b0;
      bus.PCWriteCond    = 1'b0;
      bus.Mem_W          = 1'b0;
      bus.MDR_W          = 1'b0;
      bus.IR_W           = 1'b0;
      bus.RB_W           = 1'b0;
      bus.Reg_AB_W       = 1'b0;
      bus.ALU_Out_Reg_W  = 1'b0;
      bus.EPC_W          = 1'b0;
      bus.HILO_W         = 1'b0;
      bus.divOrMult      = 1'b0;
      bus.controlDivMult = 1'b0;
      bus.ALUSrcA        = SRCA_PC;
      bus.ALUSrcB        = SRCB_B;
      bus.ALUControl     = ALU_PASS;
      bus.PCSource       = PCS_ALU;
      bus.memToReg       = M2R_ALUOUT;
      bus.regDST         = DST_RT;
      bus.IorD           = IORD_PC;
      bus.CB             = CB_EQ;
      bus.EC_CTRL        = EC_INVALID;
      case (state_q)
         ST_FETCH: begin
            bus.IorD       = IORD_PC;
            bus.ALUSrcA    = SRCA_PC;
            bus.ALUSrcB    = SRCB_FOUR;
            bus.ALUControl = ALU_ADD;
            if (cnt_q == MEM_LAST) begin
               bus.IR_W     = 1'b1;
               bus.PC_W     = 1'b1;
               bus.PCSource = PCS_ALU;
            end
         end
         ST_DECODE: begin
            bus.Reg_AB_W      = 1'b1;
            bus.ALUSrcA       = SRCA_PC;
            bus.ALUSrcB       = SRCB_SEXT_SH2;
            bus.ALUControl    = ALU_ADD;
            bus.ALU_Out_Reg_W = 1'b1;
         end
         ST_EXEC_R: begin
            bus.ALUSrcA       = SRCA_A;
            bus.ALUSrcB       = SRCB_B;
            bus.ALUControl    = funct_alu(bus.funct);
            bus.ALU_Out_Reg_W = 1'b1;
         end
         ST_WB_R: begin
            bus.regDST   = DST_RD;
            bus.memToReg = M2R_ALUOUT;
            bus.RB_W     = 1'b1;
         end
         ST_ADDI, ST_MEM_ADDR: begin
            bus.ALUSrcA       = SRCA_A;
            bus.ALUSrcB       = SRCB_SEXT;
            bus.ALUControl    = ALU_ADD;
            bus.ALU_Out_Reg_W = 1'b1;
         end
         ST_WB_I: begin
            bus.regDST   = DST_RT;
            bus.memToReg = M2R_ALUOUT;
            bus.RB_W     = 1'b1;
         end
         ST_MEM_READ: begin
            bus.IorD  = IORD_ALUOUT;
            bus.MDR_W = (cnt_q == MEM_LAST);
         end
         ST_MEM_WB: begin
            bus.regDST   = DST_RT;
            bus.memToReg = M2R_MDR;
            bus.RB_W     = 1'b1;
         end
         ST_MEM_WRITE: begin
            bus.IorD  = IORD_ALUOUT;
            bus.Mem_W = 1'b1;
         end
         ST_BRANCH: begin
            bus.ALUSrcA     = SRCA_A;
            bus.ALUSrcB     = SRCB_B;
            bus.ALUControl  = ALU_SUB;
            bus.PCWriteCond = 1'b1;
            bus.PCSource    = PCS_ALUOUT;
            bus.CB          = (bus.opcode == OP_BNE) ? CB_NE : CB_EQ;
         end
         ST_JUMP: begin
            bus.PCSource = PCS_JUMP;
            bus.PC_W     = 1'b1;
         end
         ST_JR: begin
            bus.PCSource = PCS_A;
            bus.PC_W     = 1'b1;
         end
         ST_MULT: begin
            bus.divOrMult = 1'b1;
            bus.HILO_W    = (cnt_q == MULT_LAST);
         end
         // Guard keeps a first-cycle div-by-zero from capturing HI/LO when DIV_CYCLES is 1.
         ST_DIV: begin
            bus.divOrMult = 1'b0;
            bus.HILO_W    = (cnt_q == DIV_LAST) && !((cnt_q == 6'd0) && bus.div_zero);
         end
         ST_MFHILO: begin
            bus.controlDivMult = (bus.funct == FN_MFHI);
            bus.memToReg       = M2R_HILO;
            bus.regDST         = DST_RD;
            bus.RB_W           = 1'b1;
         end
         ST_EXC_SAVE: begin
            bus.EPC_W   = 1'b1;
            bus.EC_CTRL = ec_q;
         end
         ST_EXC_LOAD: begin
            bus.IorD    = IORD_EXC;
            bus.MDR_W   = (cnt_q == MEM_LAST);
            bus.EC_CTRL = ec_q;
         end
         ST_EXC_JUMP: begin
            bus.PCSource = PCS_EXC;
            bus.PC_W     = 1'b1;
            bus.EC_CTRL  = ec_q;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: each instruction pushes its expected per-cycle
// control trace to a scoreboard, which is popped and compared on every falling edge.
module tb_mc_control_unit;
   import mc_ctrl_pkg::*;

   logic clk;
   logic reset;
   mc_control_unit_if bus ();

   mc_control_unit #(.MEM_WAIT(2), .MULT_CYCLES(33), .DIV_CYCLES(33)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [38:0] v;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   n_fail   = 0;

   localparam logic [7:0] S_PCW  = 8'h80;
   localparam logic [7:0] S_PCWC = 8'h40;
   localparam logic [7:0] S_MEMW = 8'h20;
   localparam logic [7:0] S_MDRW = 8'h10;
   localparam logic [7:0] S_IRW  = 8'h08;
   localparam logic [7:0] S_RBW  = 8'h04;
   localparam logic [7:0] S_EPCW = 8'h02;
   localparam logic [7:0] S_HILO = 8'h01;

   function automatic logic [15:0] sl(input logic [1:0] iord, input logic [2:0] pcs,
                                      input logic [2:0] m2r, input logic [1:0] dst,
                                      input logic [1:0] cb, input logic [1:0] ec,
                                      input logic dom, input logic cdm);
      return {iord, pcs, m2r, dst, cb, ec, dom, cdm};
   endfunction

   function automatic logic [9:0] al(input logic abw, input logic aow, input logic [1:0] sa,
                                     input logic [2:0] sbs, input logic [2:0] ctl);
      return {abw, aow, sa, sbs, ctl};
   endfunction

   task automatic push(input string tag, input state_t st, input logic [7:0] stb,
                       input logic [15:0] s, input logic [9:0] a);
      exp_t e;
      e.tag = tag;
      e.v   = {st, stb, s, a};
      sb.push_back(e);
   endtask

   task automatic step();
      exp_t        e;
      logic [38:0] obs;
      @(negedge clk);
      e   = sb.pop_front();
      obs = {bus.state_dbg,
             bus.PC_W, bus.PCWriteCond, bus.Mem_W, bus.MDR_W, bus.IR_W, bus.RB_W, bus.EPC_W, bus.HILO_W,
             bus.IorD, bus.PCSource, bus.memToReg, bus.regDST, bus.CB, bus.EC_CTRL,
             bus.divOrMult, bus.controlDivMult,
             bus.Reg_AB_W, bus.ALU_Out_Reg_W, bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl};
      n_checks++;
      assert (obs === e.v) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", e.tag, obs, e.v);
      end
   endtask

   task automatic drain();
      while (sb.size() > 0) step();
   endtask

   task automatic set_instr(input logic [5:0] op, input logic [5:0] fn,
                            input logic ovf, input logic dz);
      bus.opcode   = op;
      bus.funct    = fn;
      bus.overflow = ovf;
      bus.div_zero = dz;
   endtask

   task automatic push_fetch_decode(input string tag);
      push({tag, "_fetch0"}, ST_FETCH, 8'h00, 16'h0, al(0, 0, 2'b00, 3'b001, 3'b001));
      push({tag, "_fetch1"}, ST_FETCH, S_PCW | S_IRW, 16'h0, al(0, 0, 2'b00, 3'b001, 3'b001));
      push({tag, "_decode"}, ST_DECODE, 8'h00, 16'h0, al(1, 1, 2'b00, 3'b100, 3'b001));
   endtask

   task automatic push_exc(input string tag, input logic [1:0] ec);
      push({tag, "_esave"}, ST_EXC_SAVE, S_EPCW, sl(2'b00, 3'b000, 3'b000, 2'b00, 2'b00, ec, 0, 0), 10'h0);
      push({tag, "_eload0"}, ST_EXC_LOAD, 8'h00, sl(2'b10, 3'b000, 3'b000, 2'b00, 2'b00, ec, 0, 0), 10'h0);
      push({tag, "_eload1"}, ST_EXC_LOAD, S_MDRW, sl(2'b10, 3'b000, 3'b000, 2'b00, 2'b00, ec, 0, 0), 10'h0);
      push({tag, "_ejump"}, ST_EXC_JUMP, S_PCW, sl(2'b00, 3'b101, 3'b000, 2'b00, 2'b00, ec, 0, 0), 10'h0);
   endtask

   initial begin
      reset = 1'b0;
      set_instr(6'h00, 6'h20, 1'b0, 1'b0);

      repeat (3) push("reset", ST_RESET, 8'h00, 16'h0, 10'h0);
      drain();
      reset = 1'b1;

      // add, no overflow: 5 cycles
      set_instr(6'h00, 6'h20, 1'b0, 1'b0);
      push_fetch_decode("add");
      push("add_exec", ST_EXEC_R, 8'h00, 16'h0, al(0, 1, 2'b10, 3'b000, 3'b001));
      push("add_wb", ST_WB_R, S_RBW, sl(2'b00, 3'b000, 3'b000, 2'b01, 2'b00, 2'b00, 0, 0), 10'h0);
      drain();

      // addi with overflow -> exception 01
      set_instr(6'h08, 6'h00, 1'b1, 1'b0);
      push_fetch_decode("addi");
      push("addi_exec", ST_ADDI, 8'h00, 16'h0, al(0, 1, 2'b10, 3'b010, 3'b001));
      push_exc("addi", 2'b01);
      drain();

      // sub with overflow in EXEC_R -> exception 01
      set_instr(6'h00, 6'h22, 1'b1, 1'b0);
      push_fetch_decode("sub");
      push("sub_exec", ST_EXEC_R, 8'h00, 16'h0, al(0, 1, 2'b10, 3'b000, 3'b010));
      push_exc("sub", 2'b01);
      drain();

      // and ignores overflow
      set_instr(6'h00, 6'h24, 1'b1, 1'b0);
      push_fetch_decode("and");
      push("and_exec", ST_EXEC_R, 8'h00, 16'h0, al(0, 1, 2'b10, 3'b000, 3'b011));
      push("and_wb", ST_WB_R, S_RBW, sl(2'b00, 3'b000, 3'b000, 2'b01, 2'b00, 2'b00, 0, 0), 10'h0);
      drain();

      // lw: 7 cycles
      set_instr(6'h23, 6'h00, 1'b0, 1'b0);
      push_fetch_decode("lw");
      push("lw_addr", ST_MEM_ADDR, 8'h00, 16'h0, al(0, 1, 2'b10, 3'b010, 3'b001));
      push("lw_rd0", ST_MEM_READ, 8'h00, sl(2'b01, 3'b000, 3'b000, 2'b00, 2'b00, 2'b00, 0, 0), 10'h0);
      push("lw_rd1", ST_MEM_READ, S_MDRW, sl(2'b01, 3'b000, 3'b000, 2'b00, 2'b00, 2'b00, 0, 0), 10'h0);
      push("lw_wb", ST_MEM_WB, S_RBW, sl(2'b00, 3'b000, 3'b001, 2'b00, 2'b00, 2'b00, 0, 0), 10'h0);
      drain();

      // sw: 5 cycles, single Mem_W
      set_instr(6'h2B, 6'h00, 1'b0, 1'b0);
      push_fetch_decode("sw");
      push("sw_addr", ST_MEM_ADDR, 8'h00, 16'h0, al(0, 1, 2'b10, 3'b010, 3'b001));
      push("sw_wr", ST_MEM_WRITE, S_MEMW, sl(2'b01, 3'b000, 3'b000, 2'b00, 2'b00, 2'b00, 0, 0), 10'h0);
      drain();

      // div by zero -> exception 10, no HILO_W
      set_instr(6'h00, 6'h1A, 1'b0, 1'b1);
      push_fetch_decode("divz");
      push("divz_div", ST_DIV, 8'h00, 16'h0, 10'h0);
      push_exc("divz", 2'b10);
      drain();

      // div: 33 cycles, HILO_W on the last with divOrMult=0
      set_instr(6'h00, 6'h1A, 1'b0, 1'b0);
      push_fetch_decode("div");
      for (int i = 0; i < 33; i++)
         push("div_run", ST_DIV, (i == 32) ? S_HILO : 8'h00, 16'h0, 10'h0);
      drain();

      // mult: 33 cycles, divOrMult=1
      set_instr(6'h00, 6'h18, 1'b0, 1'b0);
      push_fetch_decode("mult");
      for (int i = 0; i < 33; i++)
         push("mult_run", ST_MULT, (i == 32) ? S_HILO : 8'h00,
              sl(2'b00, 3'b000, 3'b000, 2'b00, 2'b00, 2'b00, 1, 0), 10'h0);
      drain();

      // mfhi / mflo
      set_instr(6'h00, 6'h10, 1'b0, 1'b0);
      push_fetch_decode("mfhi");
      push("mfhi_wb", ST_MFHILO, S_RBW, sl(2'b00, 3'b000, 3'b010, 2'b01, 2'b00, 2'b00, 0, 1), 10'h0);
      drain();
      set_instr(6'h00, 6'h12, 1'b0, 1'b0);
      push_fetch_decode("mflo");
      push("mflo_wb", ST_MFHILO, S_RBW, sl(2'b00, 3'b000, 3'b010, 2'b01, 2'b00, 2'b00, 0, 0), 10'h0);
      drain();

      // bne and beq
      set_instr(6'h05, 6'h00, 1'b0, 1'b0);
      push_fetch_decode("bne");
      push("bne_br", ST_BRANCH, S_PCWC, sl(2'b00, 3'b001, 3'b000, 2'b00, 2'b01, 2'b00, 0, 0),
           al(0, 0, 2'b10, 3'b000, 3'b010));
      drain();
      set_instr(6'h04, 6'h00, 1'b0, 1'b0);
      push_fetch_decode("beq");
      push("beq_br", ST_BRANCH, S_PCWC, sl(2'b00, 3'b001, 3'b000, 2'b00, 2'b00, 2'b00, 0, 0),
           al(0, 0, 2'b10, 3'b000, 3'b010));
      drain();

      // j and jr
      set_instr(6'h02, 6'h00, 1'b0, 1'b0);
      push_fetch_decode("j");
      push("j_pc", ST_JUMP, S_PCW, sl(2'b00, 3'b010, 3'b000, 2'b00, 2'b00, 2'b00, 0, 0), 10'h0);
      drain();
      set_instr(6'h00, 6'h08, 1'b0, 1'b0);
      push_fetch_decode("jr");
      push("jr_pc", ST_JR, S_PCW, sl(2'b00, 3'b011, 3'b000, 2'b00, 2'b00, 2'b00, 0, 0), 10'h0);
      drain();

      // invalid opcode and invalid R funct -> exception 00
      set_instr(6'h3F, 6'h00, 1'b0, 1'b0);
      push_fetch_decode("badop");
      push_exc("badop", 2'b00);
      drain();
      set_instr(6'h00, 6'h3F, 1'b0, 1'b0);
      push_fetch_decode("badfn");
      push_exc("badfn", 2'b00);
      drain();

      // reset mid-MULT aborts with no HILO_W
      set_instr(6'h00, 6'h18, 1'b0, 1'b0);
      push_fetch_decode("mabort");
      for (int i = 0; i < 10; i++)
         push("mabort_run", ST_MULT, 8'h00, sl(2'b00, 3'b000, 3'b000, 2'b00, 2'b00, 2'b00, 1, 0), 10'h0);
      drain();
      reset = 1'b0;
      repeat (2) push("mabort_rst", ST_RESET, 8'h00, 16'h0, 10'h0);
      drain();
      reset = 1'b1;

      // recovery after abort
      set_instr(6'h02, 6'h00, 1'b0, 1'b0);
      push_fetch_decode("rec");
      push("rec_j", ST_JUMP, S_PCW, sl(2'b00, 3'b010, 3'b000, 2'b00, 2'b00, 2'b00, 0, 0), 10'h0);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
